// File: rtl/mcycle_seq_pkg.sv
// Shared core encodings: multi-cycle op codes, sequencer states and ALU controls.
package mcycle_seq_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_COMPUTE = 2'b01;
  localparam logic [1:0] ST_FIXUP   = 2'b10;
  localparam logic [1:0] ST_DONE    = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;

endpackage

// File: rtl/mcycle_seq_if.sv
// Request/result bundle between the pipeline and the multi-cycle unit.
interface mcycle_seq_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy, Done
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy, Done
  );
endinterface

// File: rtl/mcycle_seq_addsub33.sv
// WIDTH+1-bit adder/subtractor shared by the multiply and divide iterations.
module addsub33 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum,
  output logic           carry
);
  logic [WIDTH:0] b_eff;

  // On subtract, carry set means a >= b (no borrow).
  assign b_eff = sub ? ~b : b;
  assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{(WIDTH+1){1'b0}}, sub};
endmodule

// File: rtl/mcycle_seq.sv
// Multi-cycle multiply/divide sequencer: shift-add multiply, restoring divide,
// WIDTH iterations plus one sign-fixup cycle, identical latency for every op.
//
// state   | meaning
// IDLE    | waiting for Start
// COMPUTE | one multiply/divide iteration per cycle, WIDTH cycles
// FIXUP   | apply result signs and divide-by-zero override, register results
// DONE    | Done pulse; Start here chains straight into COMPUTE
module mcycle_seq
  import mcycle_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         CLK,
  input logic         RESET,
  mcycle_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]         state;
  logic [CNT_W-1:0]   iter_cnt;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opnd_b;
  logic [WIDTH-1:0]   dividend_q;
  logic [1:0]         op_q;
  logic               neg_lo;
  logic               neg_hi;
  logic               div_zero;
  logic [WIDTH-1:0]   result1;
  logic [WIDTH-1:0]   result2;

  logic               start_acc;
  logic               is_div;
  logic               op_signed;
  logic               sign1;
  logic               sign2;
  logic [WIDTH-1:0]   abs1;
  logic [WIDTH-1:0]   abs2;
  logic [WIDTH-1:0]   trial;
  logic               shift_out;
  logic               commit;
  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic [WIDTH:0]     add_sum;
  logic               add_carry;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_fix;

  assign start_acc   = ((state == ST_IDLE) || (state == ST_DONE)) && bus.Start;
  assign bus.Busy    = (state == ST_COMPUTE) || (state == ST_FIXUP) || start_acc;
  assign bus.Done    = (state == ST_DONE);
  assign bus.Result1 = result1;
  assign bus.Result2 = result2;
  assign is_div      = op_q[1];

  // Most-negative operand maps to 2^(WIDTH-1), which is still representable unsigned.
  always_comb begin
    op_signed = ~bus.MCycleOp[0];
    sign1     = op_signed & bus.Operand1[WIDTH-1];
    sign2     = op_signed & bus.Operand2[WIDTH-1];
    abs1      = sign1 ? -bus.Operand1 : bus.Operand1;
    abs2      = sign2 ? -bus.Operand2 : bus.Operand2;
  end

  always_comb begin
    shift_out   = acc_hi[WIDTH-1];
    trial       = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    add_a       = is_div ? {1'b0, trial} : {1'b0, acc_hi};
    add_b       = (is_div || acc_lo[0]) ? {1'b0, opnd_b} : '0;
    commit      = shift_out | add_carry;
    product     = {acc_hi, acc_lo};
    product_fix = neg_lo ? -product : product;
  end

  addsub33 #(.WIDTH(WIDTH)) u_addsub (
    .a     (add_a),
    .b     (add_b),
    .sub   (is_div),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      iter_cnt   <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      opnd_b     <= '0;
      dividend_q <= '0;
      op_q       <= '0;
      neg_lo     <= 1'b0;
      neg_hi     <= 1'b0;
      div_zero   <= 1'b0;
      result1    <= '0;
      result2    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.Start) begin
            state      <= ST_COMPUTE;
            iter_cnt   <= CNT_W'(WIDTH - 1);
            acc_hi     <= '0;
            acc_lo     <= abs1;
            opnd_b     <= abs2;
            op_q       <= bus.MCycleOp;
            neg_lo     <= sign1 ^ sign2;
            neg_hi     <= sign1;
            div_zero   <= (bus.Operand2 == '0);
            dividend_q <= bus.Operand1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_COMPUTE: begin
          if (is_div) begin
            acc_hi <= commit ? add_sum[WIDTH-1:0] : trial;
            acc_lo <= {acc_lo[WIDTH-2:0], commit};
          end else begin
            acc_hi <= add_sum[WIDTH:1];
            acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
          end
          if (iter_cnt == '0) state <= ST_FIXUP;
          else                iter_cnt <= iter_cnt - CNT_W'(1);
        end
        ST_FIXUP: begin
          state <= ST_DONE;
          if (!is_div) begin
            result1 <= product_fix[WIDTH-1:0];
            result2 <= product_fix[2*WIDTH-1:WIDTH];
          end else if (div_zero) begin
            result1 <= '1;
            result2 <= dividend_q;
          end else begin
            result1 <= neg_lo ? -acc_lo : acc_lo;
            result2 <= neg_hi ? -acc_hi : acc_hi;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mcycle_seq.sv
// Self-checking bench for mcycle_seq: directed corner cases plus random ops vs. an arithmetic model.
module tb_mcycle_seq;
  import mcycle_seq_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  mcycle_seq_if #(.WIDTH(W)) bus ();
  mcycle_seq #(.WIDTH(W)) dut (.CLK(clk), .RESET(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r1, output logic [31:0] r2);
    longint      sa, sb, q, rm;
    logic [63:0] t, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r1 = '0;
    r2 = '0;
    case (op)
      OP_MUL:  begin t = sa * sb; r1 = t[31:0]; r2 = t[63:32]; end
      OP_MULU: begin t = ua * ub; r1 = t[31:0]; r2 = t[63:32]; end
      default: begin
        if (b == 32'h0) begin
          r1 = 32'hFFFFFFFF;
          r2 = a;
        end else if (op == OP_DIV) begin
          q = sa / sb; rm = sa % sb;
          t = q;  r1 = t[31:0];
          t = rm; r2 = t[31:0];
        end else begin
          t = ua / ub; r1 = t[31:0];
          t = ua % ub; r2 = t[31:0];
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op (now=1: in the current cycle) and waits, bounded, for Done.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit now,
                       output int lat, output bit busy_bad, output logic [31:0] r1, output logic [31:0] r2);
    if (!now) @(negedge clk);
    bus.Start = 1'b1; bus.MCycleOp = op; bus.Operand1 = a; bus.Operand2 = b;
    #1 busy_bad = (bus.Busy !== 1'b1);
    lat = -1; r1 = 'x; r2 = 'x;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      bus.Start = 1'b0; bus.MCycleOp = 2'($urandom); bus.Operand1 = $urandom; bus.Operand2 = $urandom;
      #1;
      if (bus.Done === 1'b1) begin
        lat = c;
        if (bus.Busy !== 1'b0) busy_bad = 1'b1;
        r1 = bus.Result1; r2 = bus.Result2;
        break;
      end
      if (bus.Busy !== 1'b1) busy_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus.Start = 1'b1; bus.MCycleOp = OP_MULU; bus.Operand1 = 32'd3; bus.Operand2 = 32'd4;
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus.Busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy_comb got %b exp 1", bus.Busy); end
    bus.Start = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0)
      begin n_bad++; $display("FAIL reset_ctrl got busy=%b done=%b exp 0/0", bus.Busy, bus.Done); end
    n_cmp++; if (bus.Result1 !== 32'h0 || bus.Result2 !== 32'h0)
      begin n_bad++; $display("FAIL reset_results got %h/%h exp 0/0", bus.Result1, bus.Result2); end
    rst = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL reset_no_accept got busy=%b exp 0", bus.Busy); end
  endtask

  task automatic test_mul();
    int lat; bit bb; logic [31:0] r1, r2;
    do_op(OP_MUL, 32'hFFFFFFFD, 32'd7, 1'b0, lat, bb, r1, r2);
    n_cmp++; if (r1 !== 32'hFFFFFFEB || r2 !== 32'hFFFFFFFF)
      begin n_bad++; $display("FAIL mul_neg got %h/%h exp ffffffeb/ffffffff", r1, r2); end
    n_cmp++; if (lat != W + 2 || bb) begin n_bad++; $display("FAIL mul_timing got lat=%0d busy_bad=%0d exp 34/0", lat, bb); end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.Result1 !== 32'hFFFFFFEB || bus.Done !== 1'b0)
      begin n_bad++; $display("FAIL mul_hold got %h done=%b exp ffffffeb done=0", bus.Result1, bus.Done); end
    do_op(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bb, r1, r2);
    n_cmp++; if (r1 !== 32'h00000001 || r2 !== 32'hFFFFFFFE || lat != W + 2)
      begin n_bad++; $display("FAIL mulu_max got %h/%h lat=%0d exp 00000001/fffffffe lat=34", r1, r2, lat); end
  endtask

  task automatic test_div();
    int lat; bit bb; logic [31:0] r1, r2;
    do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, lat, bb, r1, r2);
    n_cmp++; if (r1 !== 32'hFFFFFFFD || r2 !== 32'hFFFFFFFF || lat != W + 2 || bb)
      begin n_bad++; $display("FAIL div_neg got %h/%h lat=%0d exp fffffffd/ffffffff lat=34", r1, r2, lat); end
    do_op(OP_DIVU, 32'd7, 32'd2, 1'b0, lat, bb, r1, r2);
    n_cmp++; if (r1 !== 32'd3 || r2 !== 32'd1 || lat != W + 2)
      begin n_bad++; $display("FAIL divu_small got %h/%h lat=%0d exp 3/1 lat=34", r1, r2, lat); end
  endtask

  task automatic test_special();
    int lat; bit bb; logic [31:0] r1, r2;
    do_op(OP_DIVU, 32'd100, 32'd0, 1'b0, lat, bb, r1, r2);
    n_cmp++; if (r1 !== 32'hFFFFFFFF || r2 !== 32'h64 || lat != W + 2)
      begin n_bad++; $display("FAIL divu_zero got %h/%h lat=%0d exp ffffffff/64 lat=34", r1, r2, lat); end
    do_op(OP_DIV, 32'hFFFFFFFB, 32'd0, 1'b0, lat, bb, r1, r2);
    n_cmp++; if (r1 !== 32'hFFFFFFFF || r2 !== 32'hFFFFFFFB || lat != W + 2)
      begin n_bad++; $display("FAIL div_zero got %h/%h lat=%0d exp ffffffff/fffffffb lat=34", r1, r2, lat); end
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bb, r1, r2);
    n_cmp++; if (r1 !== 32'h80000000 || r2 !== 32'h0 || lat != W + 2)
      begin n_bad++; $display("FAIL div_ovf got %h/%h lat=%0d exp 80000000/0 lat=34", r1, r2, lat); end
    do_op(OP_MUL, 32'h80000000, 32'h80000000, 1'b0, lat, bb, r1, r2);
    n_cmp++; if (r1 !== 32'h0 || r2 !== 32'h40000000)
      begin n_bad++; $display("FAIL mul_mostneg got %h/%h exp 0/40000000", r1, r2); end
  endtask

  task automatic test_ignore_restart();
    int lat; bit bb;
    @(negedge clk);
    bus.Start = 1'b1; bus.MCycleOp = OP_MUL; bus.Operand1 = 32'd5; bus.Operand2 = 32'd5;
    lat = -1; bb = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      bus.Start = (c == 10);
      if (c == 10) begin bus.Operand1 = 32'd7; bus.Operand2 = 32'd7; end
      #1;
      if (bus.Done === 1'b1) begin lat = c; break; end
      if (bus.Busy !== 1'b1) bb = 1'b1;
    end
    n_cmp++; if (lat != W + 2 || bb || bus.Result1 !== 32'd25)
      begin n_bad++; $display("FAIL restart_ignored got lat=%0d busy_bad=%0d r1=%h exp 34/0/19", lat, bb, bus.Result1); end
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    @(negedge clk);
    bus.Start = 1'b1; bus.MCycleOp = OP_DIVU; bus.Operand1 = 32'd1000; bus.Operand2 = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.Start = 1'b0;
      if (c == 10) rst = 1'b1;
    end
    @(negedge clk); #1;
    n_cmp++; if (bus.Result1 !== 32'h0 || bus.Result2 !== 32'h0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0)
      begin n_bad++; $display("FAIL abort_state got r=%h/%h busy=%b done=%b exp 0/0/0/0",
                              bus.Result1, bus.Result2, bus.Busy, bus.Done); end
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk); #1;
      if (bus.Done === 1'b1) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done) begin n_bad++; $display("FAIL abort_no_done got done pulse exp none"); end
  endtask

  task automatic test_back_to_back();
    int lat; bit bb; logic [31:0] r1, r2;
    do_op(OP_MULU, 32'd6, 32'd7, 1'b0, lat, bb, r1, r2);
    n_cmp++; if (r1 !== 32'd42 || r2 !== 32'd0 || lat != W + 2)
      begin n_bad++; $display("FAIL b2b_first got %h/%h lat=%0d exp 2a/0 lat=34", r1, r2, lat); end
    do_op(OP_DIVU, 32'd9, 32'd4, 1'b1, lat, bb, r1, r2);
    n_cmp++; if (r1 !== 32'd2 || r2 !== 32'd1 || lat != W + 2 || bb)
      begin n_bad++; $display("FAIL b2b_second got %h/%h lat=%0d busy_bad=%0d exp 2/1 lat=34", r1, r2, lat, bb); end
  endtask

  task automatic test_random();
    int lat; bit bb; logic [31:0] a, b, r1, r2, e1, e2; logic [1:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom); a = pick(); b = pick();
      model(op, a, b, e1, e2);
      do_op(op, a, b, 1'b0, lat, bb, r1, r2);
      n_cmp++; if (r1 !== e1 || r2 !== e2 || lat != W + 2 || bb)
        begin n_bad++; $display("FAIL rand_%0d op=%0d a=%h b=%h got %h/%h lat=%0d exp %h/%h lat=34",
                                i, op, a, b, r1, r2, lat, e1, e2); end
    end
  endtask

  initial begin
    bus.Start = 1'b0; bus.MCycleOp = OP_MUL; bus.Operand1 = '0; bus.Operand2 = '0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_ignore_restart();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mcycle_seq.md
MCYCLE_SEQ -- requirements
Module: mcycle_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; iteration count equals WIDTH.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 Start  in  1  request to begin an operation; sampled only in IDLE or DONE.
REQ-005 MCycleOp  in  2  00 MUL signed, 01 MULU unsigned, 10 DIV signed, 11 DIVU unsigned.
REQ-006 Operand1  in  WIDTH  multiplicand / dividend.
REQ-007 Operand2  in  WIDTH  multiplier / divisor.
REQ-008 Result1  out  WIDTH  low product / quotient.
REQ-009 Result2  out  WIDTH  high product / remainder.
REQ-010 Busy  out  1  stall request to the pipeline.
REQ-011 Done  out  1  one-cycle pulse; results valid.

Function
REQ-012 States SHALL be IDLE, COMPUTE, FIXUP, DONE.
- IDLE/DONE + Start -> COMPUTE.
- COMPUTE -> FIXUP after exactly WIDTH iterations.
- FIXUP -> DONE.
- DONE without Start -> IDLE.
REQ-013 On accepted Start, operands, op and result signs SHALL be latched; later input changes have no effect.
REQ-014 Busy SHALL equal (state is COMPUTE or FIXUP) OR (state is IDLE/DONE AND Start); it is combinational in the Start cycle.
REQ-015 Start while COMPUTE or FIXUP SHALL be ignored.
REQ-016 Latency is fixed: Start accepted at cycle 0, Done=1 and Busy=0 at cycle WIDTH+2 (34 for WIDTH=32), for every op including special cases.
REQ-017 Result1/Result2 SHALL be registered at the end of FIXUP and held until the next FIXUP completes or RESET.
REQ-018 Signed ops SHALL run on absolute values. FIXUP negates:
- product, if operand signs differ;
- quotient, if signs differ;
- remainder, if dividend negative.
REQ-019 Multiply SHALL use shift-add, one iteration per cycle. The WIDTH+1-bit sum of upper accumulator and multiplicand is kept; carry shifts into the MSB.
REQ-020 Divide SHALL be restoring, one quotient bit per cycle. A subtraction is committed when the bit shifted out of the partial remainder is 1 OR the WIDTH+1-bit difference has no borrow.
REQ-021 Divide by zero: Result1 = all ones, Result2 = Operand1 (unmodified), for both DIV and DIVU.
REQ-022 Signed overflow, DIV of most-negative / -1: Result1 = most-negative, Result2 = 0.
REQ-023 Abs of most-negative operand SHALL be 2^(WIDTH-1) unsigned, with no overflow in the iteration path.
REQ-024 Start asserted in the DONE cycle SHALL be accepted: Done=1 that cycle, COMPUTE the next.

Reset
REQ-025 RESET SHALL force IDLE with Result1=0, Result2=0, Done=0, iteration counter=0, and all datapath registers=0.
REQ-026 Busy SHALL follow REQ-014 during RESET; no operation is accepted in a RESET cycle.
REQ-027 RESET mid-operation SHALL abort it; no Done pulse is produced for the aborted op.

Structure
REQ-028 Op encodings (MUL/MULU/DIV/DIVU) and state encodings SHALL live in the shared core package, with the ALUControl constants.
REQ-029 One sub-module, addsub33: WIDTH+1-bit adder/subtractor (A, B, sub, sum with carry/borrow), shared by multiply and divide iterations.
REQ-030 Controller plus registers SHALL be a single FSM with a log2(WIDTH)+1-bit iteration counter; no multiplier or divider primitives are inferred.

Verification
REQ-031 MUL -3 x 7 -> Result1=0xFFFFFFEB, Result2=0xFFFFFFFF; Done at cycle 34; Busy high for cycles 0-33.
REQ-032 MULU 0xFFFFFFFF x 0xFFFFFFFF -> Result1=0x00000001, Result2=0xFFFFFFFE.
REQ-033 DIV -7 / 2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF; DIVU 7 / 2 -> Result1=3, Result2=1.
REQ-034 DIVU 100 / 0 -> Result1=0xFFFFFFFF, Result2=0x64. DIV 0x80000000 / 0xFFFFFFFF -> Result1=0x80000000, Result2=0.
REQ-035 Start MUL 5x5, re-pulse Start with new operands at cycle 10 -> ignored; Result1=25 at cycle 34.
REQ-036 RESET at cycle 10 -> IDLE, Result1=Result2=0, no Done. Start DIVU 9/4 in the DONE cycle -> back-to-back, Result1=2, Result2=1 after 34 more cycles.
